// File: rtl/led_scan_pkg.sv
// Shared types and constants for the LED matrix scan arbiter.
package led_scan_pkg;

  localparam int unsigned SRC_N = 3;
  localparam int unsigned ROW_W = 3;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned FRM_W = 8;
  localparam int unsigned TMO_W = 8;

  localparam int unsigned SRC_PLAY  = 0;
  localparam int unsigned SRC_LEVEL = 1;
  localparam int unsigned SRC_OVER  = 2;

  localparam logic [PIX_W-1:0] ALL_OFF  = 8'hFF;
  localparam logic [ROW_W-1:0] LAST_ROW = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    BLANK = 2'd2,
    SHOW  = 2'd3
  } scan_state_e;

  // One row of active-low column drive.
  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  localparam rgb_t RGB_OFF = '{r: ALL_OFF, g: ALL_OFF, b: ALL_OFF};

  // Fixed priority: game-over face > level banner > playfield.
  function automatic logic [SRC_N-1:0] pick_grant(input logic [SRC_N-1:0] req);
    logic [SRC_N-1:0] g;
    g = '0;
    if (req[SRC_OVER])       g[SRC_OVER]  = 1'b1;
    else if (req[SRC_LEVEL]) g[SRC_LEVEL] = 1'b1;
    else if (req[SRC_PLAY])  g[SRC_PLAY]  = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/led_scan_arbiter_if.sv
// Frame-source request/grant and row-fetch bus.
interface led_scan_arbiter_if;
  import led_scan_pkg::*;

  logic [SRC_N-1:0] req;
  logic [SRC_N-1:0] gnt;
  logic             row_req;
  logic [ROW_W-1:0] row_addr;
  logic             row_ack;
  logic [PIX_W-1:0] row_r;
  logic [PIX_W-1:0] row_g;
  logic [PIX_W-1:0] row_b;

  modport master (
    input  req, row_ack, row_r, row_g, row_b,
    output gnt, row_req, row_addr
  );

  modport slave (
    output req, row_ack, row_r, row_g, row_b,
    input  gnt, row_req, row_addr
  );

endinterface

// File: rtl/scan_tick_counter.sv
// Loadable down-counter timing the FETCH timeout, BLANK and SHOW phases.
module scan_tick_counter
  import led_scan_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt_q;

  // Load on phase entry, then count down to zero and stay there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (load)           cnt_q <= load_val;
    else if (cnt_q != '0)    cnt_q <= cnt_q - W'(1);
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/led_scan_arbiter.sv
// Arbitrates three frame sources and scans the granted source's rows onto the matrix.
module led_scan_arbiter
  import led_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 2000,
  parameter int unsigned BLANK_CYC       = 4,
  parameter int unsigned ACK_TIMEOUT     = 16,
  parameter int unsigned MIN_HOLD_FRAMES = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  led_scan_arbiter_if.master   bus,
  output logic [PIX_W-1:0]     DATA_R,
  output logic [PIX_W-1:0]     DATA_G,
  output logic [PIX_W-1:0]     DATA_B,
  output logic [ROW_W-1:0]     COMM,
  output logic                 frame_start,
  output logic [TMO_W-1:0]     timeout_cnt
);

  localparam logic [FRM_W-1:0] MIN_FRM = FRM_W'(MIN_HOLD_FRAMES);
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  scan_state_e      state_q, state_d;
  logic [SRC_N-1:0] gnt_q, gnt_d, arb_gnt;
  logic [ROW_W-1:0] row_addr_q, row_addr_d;
  logic [FRM_W-1:0] frames_q, frames_d, frames_inc;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  rgb_t             pix_q, pix_d;
  rgb_t             data_q, data_d;
  logic [ROW_W-1:0] comm_q, comm_d;
  logic             row_req_q, row_req_d;
  logic             fs_q, fs_d;
  logic             tick_load_c;
  logic [CNT_W-1:0] tick_val;
  logic             tick_done_c;

  scan_tick_counter #(.W(CNT_W)) u_tick (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (tick_load_c),
    .load_val (tick_val),
    .done_c   (tick_done_c)
  );

  // State and registered-output flops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      row_addr_q <= '0;
      frames_q   <= '0;
      tmo_q      <= '0;
      pix_q      <= RGB_OFF;
      data_q     <= RGB_OFF;
      comm_q     <= '0;
      row_req_q  <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      row_addr_q <= row_addr_d;
      frames_q   <= frames_d;
      tmo_q      <= tmo_d;
      pix_q      <= pix_d;
      data_q     <= data_d;
      comm_q     <= comm_d;
      row_req_q  <= row_req_d;
      fs_q       <= fs_d;
    end
  end

  // Next-state, arbitration and next-output logic.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    row_addr_d  = row_addr_q;
    frames_d    = frames_q;
    tmo_d       = tmo_q;
    pix_d       = pix_q;
    data_d      = data_q;
    comm_d      = comm_q;
    row_req_d   = 1'b0;
    fs_d        = 1'b0;
    tick_load_c = 1'b0;
    tick_val    = '0;
    arb_gnt     = pick_grant(bus.req);
    frames_inc  = (frames_q < MIN_FRM) ? frames_q + FRM_W'(1) : frames_q;

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|bus.req) begin
          gnt_d      = arb_gnt;
          frames_d   = '0;
          row_addr_d = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        // A late ack in the expiry cycle still delivers its data.
        if (bus.row_ack) begin
          pix_d   = '{r: bus.row_r, g: bus.row_g, b: bus.row_b};
          state_d = BLANK;
        end else if (tick_done_c) begin
          pix_d = RGB_OFF;
          if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
          state_d = BLANK;
        end
      end
      BLANK: begin
        if (tick_done_c) state_d = SHOW;
      end
      SHOW: begin
        if (tick_done_c) begin
          if (row_addr_q != LAST_ROW) begin
            row_addr_d = row_addr_q + ROW_W'(1);
            state_d    = FETCH;
          end else begin
            // Frame boundary: the only point where the grant may move.
            row_addr_d = '0;
            if (frames_inc < MIN_FRM) begin
              frames_d = frames_inc;
              state_d  = FETCH;
            end else if (|bus.req) begin
              gnt_d    = arb_gnt;
              frames_d = (arb_gnt != gnt_q) ? '0 : frames_inc;
              state_d  = FETCH;
            end else begin
              gnt_d    = '0;
              frames_d = '0;
              state_d  = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      IDLE, BLANK: data_d = RGB_OFF;
      SHOW:        data_d = pix_d;
      default:     data_d = data_q;
    endcase

    if (state_d == BLANK) comm_d = row_addr_d;

    row_req_d   = (state_d == FETCH);
    fs_d        = (state_d == FETCH) && (state_q != FETCH) && (row_addr_d == '0);
    tick_load_c = (state_d != state_q);

    case (state_d)
      FETCH:   tick_val = CNT_W'(ACK_TIMEOUT - 1);
      BLANK:   tick_val = CNT_W'(BLANK_CYC - 1);
      SHOW:    tick_val = CNT_W'(SCAN_DIV - 1);
      default: tick_val = '0;
    endcase
  end

  assign bus.gnt      = gnt_q;
  assign bus.row_req  = row_req_q;
  assign bus.row_addr = row_addr_q;
  assign DATA_R       = data_q.r;
  assign DATA_G       = data_q.g;
  assign DATA_B       = data_q.b;
  assign COMM         = comm_q;
  assign frame_start  = fs_q;
  assign timeout_cnt  = tmo_q;

endmodule

// File: tb/tb_led_scan_arbiter.sv
// Directed scoreboard bench for led_scan_arbiter.
module tb_led_scan_arbiter;
  import led_scan_pkg::*;

  localparam int unsigned T_SCAN  = 4;
  localparam int unsigned T_BLANK = 2;
  localparam int unsigned T_ACK   = 3;
  localparam int unsigned T_HOLD  = 2;
  localparam int          NO_ACK  = -1;
  localparam int          NO_CHG  = -1;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] DATA_R, DATA_G, DATA_B;
  logic [2:0] COMM;
  logic       frame_start;
  logic [7:0] timeout_cnt;

  int   vectors = 0;
  int   miscompares = 0;
  rgb_t exp_q[$];
  rgb_t last_data;
  logic [2:0] last_comm;
  int   exp_tmo;

  led_scan_arbiter_if bus();

  led_scan_arbiter #(
    .SCAN_DIV        (T_SCAN),
    .BLANK_CYC       (T_BLANK),
    .ACK_TIMEOUT     (T_ACK),
    .MIN_HOLD_FRAMES (T_HOLD)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .bus         (bus),
    .DATA_R      (DATA_R),
    .DATA_G      (DATA_G),
    .DATA_B      (DATA_B),
    .COMM        (COMM),
    .frame_start (frame_start),
    .timeout_cnt (timeout_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cur_data();
    return 32'({DATA_R, DATA_G, DATA_B});
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_data"},     cur_data(), 32'(RGB_OFF));
    check({tag, "_comm"},     32'(COMM), 32'd0);
    check({tag, "_gnt"},      32'(bus.gnt), 32'd0);
    check({tag, "_row_req"},  32'(bus.row_req), 32'd0);
    check({tag, "_row_addr"}, 32'(bus.row_addr), 32'd0);
    check({tag, "_fs"},       32'(frame_start), 32'd0);
    check({tag, "_tmo"},      32'(timeout_cnt), 32'd0);
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("idle_gnt", 32'(bus.gnt), 32'd0);
      check("idle_row_req", 32'(bus.row_req), 32'd0);
      check("idle_data", cur_data(), 32'(RGB_OFF));
    end
    last_data = RGB_OFF;
  endtask

  // One row: fetch handshake (or timeout), blank, then show_n show cycles.
  task automatic do_row(input int row, input int ack_dly, input logic [7:0] pix,
                        input logic [2:0] exp_gnt, input int show_n);
    bit   seen;
    rgb_t exp;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (bus.row_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check($sformatf("r%0d_req_seen", row), 32'(seen), 32'd1);
    check($sformatf("r%0d_fs", row), 32'(frame_start), 32'(row == 0));
    check($sformatf("r%0d_addr", row), 32'(bus.row_addr), 32'(row));
    check($sformatf("r%0d_gnt", row), 32'(bus.gnt), 32'(exp_gnt));
    check($sformatf("r%0d_fetch_hold", row), cur_data(), 32'(last_data));
    check($sformatf("r%0d_fetch_comm", row), 32'(COMM), 32'(last_comm));

    if (ack_dly >= 0 && ack_dly < int'(T_ACK)) begin
      for (int i = 0; i < ack_dly; i++) begin
        @(negedge CLK);
        check($sformatf("r%0d_req_held", row), 32'(bus.row_req), 32'd1);
      end
      bus.row_ack = 1'b1;
      bus.row_r   = pix;
      bus.row_g   = ~pix;
      bus.row_b   = {pix[3:0], pix[7:4]};
      exp_q.push_back('{r: pix, g: ~pix, b: {pix[3:0], pix[7:4]}});
      @(negedge CLK);
    end else begin
      for (int i = 0; i < int'(T_ACK) - 1; i++) begin
        @(negedge CLK);
        check($sformatf("r%0d_req_held", row), 32'(bus.row_req), 32'd1);
      end
      exp_q.push_back(RGB_OFF);
      exp_tmo = (exp_tmo < 255) ? exp_tmo + 1 : 255;
      @(negedge CLK);
    end

    // Blank phase; a stray ack here must not be taken.
    last_comm = 3'(row);
    check($sformatf("r%0d_req_fall", row), 32'(bus.row_req), 32'd0);
    check($sformatf("r%0d_fs_low", row), 32'(frame_start), 32'd0);
    check($sformatf("r%0d_tmo", row), 32'(timeout_cnt), 32'(exp_tmo));
    bus.row_ack = 1'b1;
    bus.row_r   = 8'h00;
    bus.row_g   = 8'h00;
    bus.row_b   = 8'h00;
    for (int i = 0; i < int'(T_BLANK); i++) begin
      if (i > 0) begin
        @(negedge CLK);
        bus.row_ack = 1'b0;
      end
      check($sformatf("r%0d_blank_data", row), cur_data(), 32'(RGB_OFF));
      check($sformatf("r%0d_blank_comm", row), 32'(COMM), 32'(row));
    end
    bus.row_ack = 1'b0;

    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      exp = RGB_OFF;
    end else begin
      exp = exp_q.pop_front();
    end
    for (int i = 0; i < show_n; i++) begin
      @(negedge CLK);
      check($sformatf("r%0d_show_data", row), cur_data(), 32'(exp));
      check($sformatf("r%0d_show_comm", row), 32'(COMM), 32'(row));
    end
    last_data = exp;
  endtask

  task automatic do_frame(input int ack_dly, input logic [7:0] pix, input logic [2:0] exp_gnt,
                          input int chg_row, input logic [2:0] chg_req);
    for (int r = 0; r < 8; r++) begin
      if (r == chg_row) bus.req = chg_req;
      do_row(r, ack_dly, pix ^ 8'(r), exp_gnt, int'(T_SCAN));
    end
  endtask

  initial begin
    RST_N       = 1'b0;
    bus.req     = 3'b000;
    bus.row_ack = 1'b0;
    bus.row_r   = 8'h00;
    bus.row_g   = 8'h00;
    bus.row_b   = 8'h00;
    last_data   = RGB_OFF;
    last_comm   = 3'd0;
    exp_tmo     = 0;

    // Reset values, then idle with no requests.
    repeat (3) @(negedge CLK);
    check_reset("reset");
    RST_N = 1'b1;
    check_idle(3);

    // Playfield alone, two frames, then drop the request.
    bus.req = 3'b001;
    do_frame(0, 8'hA5, 3'b001, NO_CHG, 3'b000);
    do_frame(0, 8'hA5, 3'b001, 4, 3'b000);
    check_idle(4);

    // Game-over rises mid-frame: grant held through the minimum hold.
    bus.req = 3'b001;
    do_frame(0, 8'h5A, 3'b001, 3, 3'b101);
    do_frame(0, 8'hC3, 3'b001, NO_CHG, 3'b000);
    do_frame(1, 8'h96, 3'b100, NO_CHG, 3'b000);

    // Requests vanish after one granted frame: one more frame, then idle.
    bus.req = 3'b000;
    do_frame(0, 8'h0F, 3'b100, NO_CHG, 3'b000);
    check_idle(6);

    // Ack in the timeout expiry cycle wins.
    bus.req = 3'b001;
    do_frame(int'(T_ACK) - 1, 8'h3C, 3'b001, NO_CHG, 3'b000);

    // Source never acks: counter climbs by 8 per frame and saturates.
    for (int f = 0; f < 32; f++)
      do_frame(NO_ACK, 8'h00, 3'b001, (f == 31) ? 2 : NO_CHG, 3'b000);
    check_idle(3);
    check("tmo_saturated", 32'(timeout_cnt), 32'd255);

    // Reset during show of row 5, then a fresh frame from row 0.
    bus.req = 3'b010;
    for (int r = 0; r < 5; r++) do_row(r, 0, 8'h11 + 8'(r), 3'b010, int'(T_SCAN));
    do_row(5, 0, 8'h66, 3'b010, 2);
    RST_N = 1'b0;
    #1;
    check_reset("midreset");
    @(negedge CLK);
    check_reset("midreset_hold");
    exp_q.delete();
    last_data = RGB_OFF;
    last_comm = 3'd0;
    exp_tmo   = 0;
    RST_N = 1'b1;
    do_frame(0, 8'h81, 3'b010, NO_CHG, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_scan_arbiter.md
LED_SCAN_ARBITER -- requirements
Module: led_scan_arbiter

Interface
REQ-001 Clocking SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter SCAN_DIV, default 2000: cycles each row is shown.
REQ-003 Parameter BLANK_CYC, default 4: cycles of all-off before each row is shown.
REQ-004 Parameter ACK_TIMEOUT, default 16: cycles to wait for row_ack before abandoning a fetch.
REQ-005 Parameter MIN_HOLD_FRAMES, default 2: minimum number of whole frames a grant is held.
REQ-006 Port CLK  in  1  system clock.
REQ-007 Port RST_N  in  1  asynchronous active-low reset.
REQ-008 Port req  in  3  frame-source requests; [0] playfield, [1] level banner, [2] game-over face; priority 2>1>0.
REQ-009 Port gnt  out  3  one-hot grant, or zero when idle; the external mux selects the row bus with it.
REQ-010 Port row_req  out  1  fetch request for row row_addr.
REQ-011 Port row_addr  out  3  row being fetched, 0..7.
REQ-012 Port row_ack  in  1  row data valid from the granted source.
REQ-013 Port row_r, row_g, row_b  in  8 each  row pixels; active-low (1 = off).
REQ-014 Port DATA_R, DATA_G, DATA_B  out  8 each  registered matrix column drive; active-low.
REQ-015 Port COMM  out  3  registered row select.
REQ-016 Port frame_start  out  1  one-cycle pulse at the start of each granted frame.
REQ-017 Port timeout_cnt  out  8  count of fetch timeouts; saturates at 255.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, BLANK and SHOW.
REQ-019 IDLE: DATA_* SHALL be 8'hFF and gnt SHALL be 0; when any req bit is high, grant the highest-priority request, clear frames_shown, set row_addr=0 and enter FETCH on the next cycle.
REQ-020 FETCH: row_req SHALL be 1 and DATA_*/COMM SHALL hold their previous values; on row_ack, latch row_r/g/b and go to BLANK.
REQ-021 FETCH: if ACK_TIMEOUT cycles pass without row_ack, latch 8'hFF on all colours, increment timeout_cnt (saturating) and go to BLANK.
REQ-022 If row_ack arrives in the same cycle the timeout expires, row_ack SHALL win and timeout_cnt SHALL not change.
REQ-023 row_req SHALL fall in the cycle after row_ack is sampled; row_ack SHALL be ignored while row_req is 0.
REQ-024 BLANK: DATA_* SHALL be 8'hFF and COMM SHALL be row_addr for exactly BLANK_CYC cycles, then go to SHOW.
REQ-025 SHOW: DATA_* SHALL show the latched row for exactly SCAN_DIV cycles.
REQ-026 At the end of SHOW, if row_addr<7: increment row_addr and go to FETCH.
REQ-027 At the end of SHOW, if row_addr==7: increment frames_shown (saturating at MIN_HOLD_FRAMES), wrap row_addr to 0, then run arbitration.
REQ-028 Arbitration SHALL happen only at frame boundaries; gnt SHALL never change mid-frame.
REQ-029 At a frame boundary with frames_shown<MIN_HOLD_FRAMES, the current grant SHALL be kept even if its req is low or a higher-priority req is high.
REQ-030 At a frame boundary with frames_shown==MIN_HOLD_FRAMES:
- grant the highest-priority active req;
- clear frames_shown if the grant changes;
- go to IDLE (gnt=0) if no req is active.
REQ-031 frame_start SHALL pulse in the first FETCH cycle of row 0 of every frame, including the first frame after IDLE.

Reset
REQ-032 While RST_N=0, outputs SHALL be:
- DATA_R/G/B=8'hFF;
- COMM=0, gnt=0, row_req=0, row_addr=0;
- frame_start=0, timeout_cnt=0.
REQ-033 While RST_N=0, the FSM SHALL be IDLE and all internal counters SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL take effect immediately with no completion of the row; after release, the block SHALL re-arbitrate from IDLE.

Structure
REQ-035 Package led_scan_pkg SHALL hold:
- the state enum;
- source index constants SRC_PLAY=0, SRC_LEVEL=1, SRC_OVER=2;
- ALL_OFF=8'hFF.
REQ-036 The BLANK/SHOW/timeout cycle counting SHALL be one sub-module, scan_tick_counter: loadable down-counter with a done flag.

Verification (SCAN_DIV=4, BLANK_CYC=2, ACK_TIMEOUT=3, MIN_HOLD_FRAMES=2)
REQ-037 Scenario 1: req=001, ack 1 cycle after each row_req, row data=8'hA5 -> gnt=001; per row, 2 cycles of DATA=FF then 4 cycles of A5; COMM runs 0..7; frame_start every frame.
REQ-038 Scenario 2: req=001, then req[2] rises mid-frame 0 -> gnt stays 001 until the end of frame 1, then becomes 100 at the frame-1 boundary.
REQ-039 Scenario 3: gnt=100, req drops to 000 after 1 frame -> 100 is held one more frame, then IDLE with DATA=FF and gnt=0.
REQ-040 Scenario 4: row_ack never asserted -> each row shows FF; timeout_cnt=8 after one frame; after 32 frames it saturates at 255.
REQ-041 Scenario 5: row_ack in the same cycle as timeout expiry -> data latched, timeout_cnt unchanged.
REQ-042 Scenario 6: RST_N pulsed low during SHOW of row 5 -> outputs immediately take reset values; after release, a fresh frame starts at row 0 with frame_start.
